// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: BCD/segment widths and active-low 7-segment glyphs.
package scoreboard_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   // Active-low patterns, bit 0 = segment a
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit adder stage: digit + add (0..10) + carry_in, with decimal carry-out.
module bcd_digit
   import scoreboard_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic [BCD_W-1:0] add,
   input  logic             carry_in,
   output logic [BCD_W-1:0] next_digit,
   output logic             carry_out
);

   logic [BCD_W:0] sum;

   // Max sum is 9 + 10 = 19 on the units digit, so one subtraction of ten suffices
   always_comb begin
      sum        = (BCD_W+1)'(digit) + (BCD_W+1)'(add) + (BCD_W+1)'(carry_in);
      next_digit = sum[BCD_W-1:0];
      carry_out  = 1'b0;
      if (sum >= 5'd10) begin
         next_digit = BCD_W'(sum - 5'd10);
         carry_out  = 1'b1;
      end
   end

endmodule

// File: rtl/hex_decoder.sv
// Combinational decode of one BCD digit to an active-low 7-segment pattern.
module hex_decoder
   import scoreboard_pkg::*;
(
   input  logic [BCD_W-1:0] hex,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_score_counter.sv
// N-digit BCD score counter advanced by a programmable tick and bonus pulses,
// with saturate/wrap overflow handling and per-digit 7-segment decode.
module bcd_score_counter
   import scoreboard_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      run,
   input  logic                      clear,
   input  logic                      bonus_valid,
   input  logic [3:0]                bonus_pts,
   output logic [4*NUM_DIGITS-1:0]   digits,
   output logic [7*NUM_DIGITS-1:0]   segs,
   output logic                      tick,
   output logic                      at_max,
   output logic                      wrapped
);

   localparam int unsigned DIV_W   = $clog2(TICK_DIV);
   localparam int unsigned SCORE_W = BCD_W * NUM_DIGITS;
   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [SCORE_W-1:0] ALL_NINES = {NUM_DIGITS{BCD_MAX}};

   logic [DIV_W-1:0]   div_cnt;
   logic [BCD_W-1:0]   bonus_clip;
   logic [BCD_W-1:0]   inc;
   logic [SCORE_W-1:0] sum_digits;
   logic [SCORE_W-1:0] next_score;
   logic [NUM_DIGITS:0] carry;

   assign tick = run && !reset && (div_cnt == DIV_LAST);

   // Tick divider: holds while run is low
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         div_cnt <= '0;
      end else if (run) begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end
   end

   always_comb begin
      bonus_clip = (bonus_pts > BCD_MAX) ? BCD_MAX : bonus_pts;
      inc        = BCD_W'(tick) + (bonus_valid ? bonus_clip : '0);
   end

   assign carry[0] = 1'b0;

   // Single-cycle ripple adder across all digits, plus display decode
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      logic [BCD_W-1:0] add_k;
      assign add_k = (k == 0) ? inc : '0;

      bcd_digit u_digit (
         .digit      (digits[BCD_W*k +: BCD_W]),
         .add        (add_k),
         .carry_in   (carry[k]),
         .next_digit (sum_digits[BCD_W*k +: BCD_W]),
         .carry_out  (carry[k+1])
      );

      hex_decoder u_hex (
         .hex (digits[BCD_W*k +: BCD_W]),
         .seg (segs[SEG_W*k +: SEG_W])
      );
   end

   always_comb begin
      next_score = sum_digits;
      if (SATURATE && carry[NUM_DIGITS]) begin
         next_score = ALL_NINES;
      end
   end

   // Score register and flags; clear discards any same-cycle increment
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         digits  <= '0;
         at_max  <= 1'b0;
         wrapped <= 1'b0;
      end else begin
         digits  <= next_score;
         at_max  <= (next_score == ALL_NINES);
         wrapped <= !SATURATE && carry[NUM_DIGITS];
      end
   end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter: a saturating and a wrapping instance
// share stimulus and are checked against an integer reference model.
module tb_bcd_score_counter;

   localparam int ND = 3;
   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset, run, clear, bonus_valid;
   logic [3:0]  bonus_pts;
   logic [11:0] dig_s, dig_w;
   logic [20:0] seg_s, seg_w;
   logic        tick_s, tick_w, am_s, am_w, wr_s, wr_w;

   always #5 clk = ~clk;

   bcd_score_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .run(run), .clear(clear),
      .bonus_valid(bonus_valid), .bonus_pts(bonus_pts),
      .digits(dig_s), .segs(seg_s), .tick(tick_s), .at_max(am_s), .wrapped(wr_s)
   );

   bcd_score_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .run(run), .clear(clear),
      .bonus_valid(bonus_valid), .bonus_pts(bonus_pts),
      .digits(dig_w), .segs(seg_w), .tick(tick_w), .at_max(am_w), .wrapped(wr_w)
   );

   typedef struct packed {
      logic [11:0] dig_s, dig_w;
      logic [20:0] seg_s, seg_w;
      logic        am_s, am_w, wr_s, wr_w;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int ms_s = 0, ms_w = 0, mdiv = 0;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7f;
      endcase
   endfunction

   function automatic logic [11:0] bcd3(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic logic [20:0] seg3(input int v);
      return {seg7(v / 100 % 10), seg7(v / 10 % 10), seg7(v % 10)};
   endfunction

   task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check comb tick, model, push, then pop/compare after edge
   task automatic step(input logic r, input logic c, input logic bv,
                       input logic [3:0] bp, input logic rs = 1'b0);
      exp_t e;
      bit   mt;
      int   inc, s;
      reset = rs; run = r; clear = c; bonus_valid = bv; bonus_pts = bp;
      @(negedge clk);
      mt = r && !rs && (mdiv == TD - 1);
      check1("tick_sat", 32'(tick_s), 32'(mt));
      check1("tick_wrap", 32'(tick_w), 32'(mt));
      e.wr_w = 1'b0;
      if (rs || c) begin
         ms_s = 0; ms_w = 0; mdiv = 0;
      end else begin
         inc = int'(mt) + (bv ? ((bp > 4'd9) ? 9 : int'(bp)) : 0);
         s = ms_s + inc;
         ms_s = (s > 999) ? 999 : s;
         s = ms_w + inc;
         e.wr_w = (s > 999);
         ms_w = s % 1000;
         if (r) mdiv = (mdiv == TD - 1) ? 0 : mdiv + 1;
      end
      e.dig_s = bcd3(ms_s);
      e.dig_w = bcd3(ms_w);
      e.seg_s = seg3(ms_s);
      e.seg_w = seg3(ms_w);
      e.am_s  = (ms_s == 999);
      e.am_w  = (ms_w == 999);
      e.wr_s  = 1'b0;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check1("digits_sat", 32'(dig_s), 32'(e.dig_s));
      check1("digits_wrap", 32'(dig_w), 32'(e.dig_w));
      check1("segs_sat", 32'(seg_s), 32'(e.seg_s));
      check1("segs_wrap", 32'(seg_w), 32'(e.seg_w));
      check1("at_max_sat", 32'(am_s), 32'(e.am_s));
      check1("at_max_wrap", 32'(am_w), 32'(e.am_w));
      check1("wrapped_sat", 32'(wr_s), 32'(e.wr_s));
      check1("wrapped_wrap", 32'(wr_w), 32'(e.wr_w));
   endtask

   // Paused divider; bonuses only, reaching target exactly
   task automatic bonus_to(input int target);
      while (ms_s + 9 <= target) step(1'b0, 1'b0, 1'b1, 4'd9);
      if (ms_s < target) step(1'b0, 1'b0, 1'b1, 4'(target - ms_s));
   endtask

   // Run until the next cycle is a tick cycle
   task automatic advance_to_tick();
      for (int i = 0; i < 2 * TD && mdiv != TD - 1; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; clear = 1'b0; bonus_valid = 1'b0; bonus_pts = 4'd0;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

      // Ticks at cycles 3, 7, 11 -> score 3
      repeat (12) step(1'b1, 1'b0, 1'b0, 4'd0);

      // Carry ripple 199 -> 200 on a tick
      bonus_to(199);
      advance_to_tick();
      step(1'b1, 1'b0, 1'b0, 4'd0);

      // Clear wins over a same-cycle tick and bonus; divider restarts
      advance_to_tick();
      step(1'b1, 1'b1, 1'b1, 4'd9);
      repeat (TD + 1) step(1'b1, 1'b0, 1'b0, 4'd0);

      // Pause run for 5 cycles
      repeat (2) step(1'b1, 1'b0, 1'b0, 4'd0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 4'd0);
      repeat (6) step(1'b1, 1'b0, 1'b0, 4'd0);

      // 95 + tick + clipped bonus 15 -> 105
      step(1'b0, 1'b1, 1'b0, 4'd0);
      bonus_to(95);
      advance_to_tick();
      step(1'b1, 1'b0, 1'b1, 4'hF);

      // 995 + 9: saturate to 999 / wrap to 004, then a further tick
      step(1'b0, 1'b1, 1'b0, 4'd0);
      bonus_to(995);
      step(1'b0, 1'b0, 1'b1, 4'd9);
      advance_to_tick();
      step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0);

      // 998 + 5: saturate to 999 / wrap to 003, wrapped lasts one cycle
      step(1'b0, 1'b1, 1'b0, 4'd0);
      bonus_to(998);
      step(1'b0, 1'b0, 1'b1, 4'd5);
      step(1'b0, 1'b0, 1'b0, 4'd0);

      // Reset mid-count on a would-be tick cycle
      repeat (5) step(1'b1, 1'b0, 1'b1, 4'd3);
      advance_to_tick();
      step(1'b1, 1'b0, 1'b1, 4'd2, 1'b1);
      repeat (TD + 1) step(1'b1, 1'b0, 1'b0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
